// File: rtl/wrapper_packet_framer_if.sv
`default_nettype none
// ============================================================================
// wrapper_packet_framer_if : accelerator-in / deconstructor-out packet streams
// Revision 1.0
// ============================================================================
interface wrapper_packet_framer_if #(
  parameter int PACKETWIDTH = 256,
  parameter int REMAINWIDTH = 6
);
  logic [PACKETWIDTH-1:0] acc_data;
  logic                   acc_data_valid;
  logic                   acc_data_ready;
  logic [PACKETWIDTH-1:0] packet_data;
  logic                   packet_data_last;
  logic [REMAINWIDTH-1:0] packet_data_remain;
  logic                   packet_data_valid;
  logic                   packet_data_ready;

  modport slave (
    input  acc_data, acc_data_valid,
    output acc_data_ready,
    output packet_data, packet_data_last, packet_data_remain, packet_data_valid,
    input  packet_data_ready
  );

  modport master (
    output acc_data, acc_data_valid,
    input  acc_data_ready,
    input  packet_data, packet_data_last, packet_data_remain, packet_data_valid,
    output packet_data_ready
  );
endinterface
`default_nettype wire

// File: rtl/wrapper_packet_framer.sv
`default_nettype none
// ============================================================================
// wrapper_packet_framer : FIFO packet buffer with block last/remain tagging;
// WRAPPER_PACKET_FRAMER_STATS_EN adds a block_count output. Revision 1.0
// ============================================================================
module wrapper_packet_framer #(
  parameter int ADDRWIDTH   = 11,
  parameter int PACKETWIDTH = 256,
  parameter int FIFO_DEPTH  = 4,
  localparam int PACKETSPACEWIDTH = ADDRWIDTH - $clog2(PACKETWIDTH/8),
  localparam int LVLW = $clog2(FIFO_DEPTH) + 1
) (
  input  wire logic                      hclk,
  input  wire logic                      hresetn,
  input  wire logic [PACKETSPACEWIDTH:0] cfg_block_packets,
  input  wire logic                      framer_abort,
  wrapper_packet_framer_if.slave         bus,
  output logic [LVLW-1:0]                fifo_level,
  output logic                           framer_idle
`ifdef WRAPPER_PACKET_FRAMER_STATS_EN
  ,
  output logic [15:0]                    block_count
`endif
);

  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int PSW  = PACKETSPACEWIDTH;
  localparam int EW   = PACKETWIDTH + 1 + PSW;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  localparam logic [PSW:0]      c_LEN_ONE = {{PSW{1'b0}}, 1'b1};
  localparam logic [PSW:0]      c_LEN_MAX = {1'b1, {PSW{1'b0}}};
  localparam logic [PSW-1:0]    c_CNT_ONE = PSW'(1);
  localparam logic [PTRW-1:0]   c_PTR_ONE = PTRW'(1);
  localparam logic [LVLW-1:0]   c_LVL_ONE = LVLW'(1);
  localparam logic [LVLW-1:0]   c_DEPTH   = LVLW'(FIFO_DEPTH);

  logic [EW-1:0]          r_mem [FIFO_DEPTH];
  logic [PTRW-1:0]        r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [LVLW-1:0]        r_level, w_level_nxt;
  logic                   r_ready, r_valid;
  logic [PACKETWIDTH-1:0] r_head_data;
  logic                   r_head_last;
  logic [PSW-1:0]         r_head_remain;
  logic [EW-1:0]          w_head_nxt;

  logic [0:0]             r_state, w_state_nxt;
  logic [PSW-1:0]         r_cnt, w_cnt_nxt;
  logic [PSW:0]           w_blk_len;
  logic [PSW-1:0]         w_blk_m1, w_blk_m2;
  logic                   w_tag_last;
  logic [PSW-1:0]         w_tag_remain;
  logic                   w_push, w_pop;

  assign w_push = bus.acc_data_valid && r_ready && !framer_abort;
  assign w_pop  = r_valid && bus.packet_data_ready && !framer_abort;

  // Block length is max(cfg,1) clamped to 2^PSW; low PSW bits minus 1 wrap correctly at the clamp.
  always_comb begin
    if (cfg_block_packets == '0)
      w_blk_len = c_LEN_ONE;
    else if (cfg_block_packets > c_LEN_MAX)
      w_blk_len = c_LEN_MAX;
    else
      w_blk_len = cfg_block_packets;
    w_blk_m1 = w_blk_len[PSW-1:0] - c_CNT_ONE;
    w_blk_m2 = w_blk_m1 - c_CNT_ONE;
  end

  always_ff @(posedge hclk) begin
    if (!hresetn || framer_abort) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_push) begin
      case (r_state)
        S_IDLE: begin
          if (!w_tag_last) begin
            w_state_nxt = S_ACTIVE;
            w_cnt_nxt   = w_blk_m2;
          end
        end
        default: begin
          if (w_tag_last)
            w_state_nxt = S_IDLE;
          else
            w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      endcase
    end
  end

  always_comb begin
    if (r_state == S_ACTIVE) begin
      w_tag_remain = r_cnt;
      w_tag_last   = (r_cnt == '0);
    end else begin
      w_tag_remain = w_blk_m1;
      w_tag_last   = (w_blk_len == c_LEN_ONE);
    end
  end

  always_ff @(posedge hclk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {bus.acc_data, w_tag_last, w_tag_remain};
  end

  // The next head bypasses memory when the entry being written is the one about to be at the head.
  always_comb begin
    w_wr_ptr_nxt = w_push ? r_wr_ptr + c_PTR_ONE : r_wr_ptr;
    w_rd_ptr_nxt = w_pop  ? r_rd_ptr + c_PTR_ONE : r_rd_ptr;
    w_level_nxt  = r_level;
    if (w_push && !w_pop)
      w_level_nxt = r_level + c_LVL_ONE;
    else if (!w_push && w_pop)
      w_level_nxt = r_level - c_LVL_ONE;
    if (w_push && (r_wr_ptr == w_rd_ptr_nxt))
      w_head_nxt = {bus.acc_data, w_tag_last, w_tag_remain};
    else
      w_head_nxt = r_mem[w_rd_ptr_nxt];
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_valid       <= 1'b0;
      r_ready       <= 1'b0;
      r_head_data   <= '0;
      r_head_last   <= 1'b0;
      r_head_remain <= '0;
    end else if (framer_abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level  <= w_level_nxt;
      r_valid  <= (w_level_nxt != '0);
      r_ready  <= (w_level_nxt < c_DEPTH);
      if (w_level_nxt != '0)
        {r_head_data, r_head_last, r_head_remain} <= w_head_nxt;
    end
  end

`ifdef WRAPPER_PACKET_FRAMER_STATS_EN
  logic [15:0] r_block_count;

  always_ff @(posedge hclk) begin
    if (!hresetn)
      r_block_count <= '0;
    else if (w_push && w_tag_last)
      r_block_count <= r_block_count + 16'd1;
  end

  assign block_count = r_block_count;
`endif

  assign bus.acc_data_ready     = r_ready;
  assign bus.packet_data        = r_head_data;
  assign bus.packet_data_last   = r_head_last;
  assign bus.packet_data_remain = r_head_remain;
  assign bus.packet_data_valid  = r_valid;
  assign fifo_level             = r_level;
  assign framer_idle            = (r_state == S_IDLE) && (r_level == '0);

endmodule
`default_nettype wire

// File: tb/tb_wrapper_packet_framer.sv
`default_nettype none
// ============================================================================
// tb_wrapper_packet_framer : directed self-checking bench for the framer
// Revision 1.0
// ============================================================================
module tb_wrapper_packet_framer;

  logic       hclk;
  logic       hresetn;
  logic [6:0] cfg_block_packets;
  logic       framer_abort;
  logic [2:0] fifo_level;
  logic       framer_idle;
`ifdef WRAPPER_PACKET_FRAMER_STATS_EN
  logic [15:0] block_count;
  logic [15:0] bc_base;
`endif

  int n_checks = 0;
  int n_errors = 0;

  wrapper_packet_framer_if #(.PACKETWIDTH(256), .REMAINWIDTH(6)) bus ();

  wrapper_packet_framer #(
    .ADDRWIDTH  (11),
    .PACKETWIDTH(256),
    .FIFO_DEPTH (4)
  ) dut (
    .hclk             (hclk),
    .hresetn          (hresetn),
    .cfg_block_packets(cfg_block_packets),
    .framer_abort     (framer_abort),
    .bus              (bus),
    .fifo_level       (fifo_level),
    .framer_idle      (framer_idle)
`ifdef WRAPPER_PACKET_FRAMER_STATS_EN
    ,
    .block_count      (block_count)
`endif
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [255:0] pkt(input int k);
    pkt = {8{32'(k) ^ 32'hA5A5_0000}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk_head(input string tag, input int k, input logic last, input int rem);
    chk({tag, "_valid"}, bus.packet_data_valid, 1'b1);
    chk({tag, "_data"}, bus.packet_data, pkt(k));
    chk({tag, "_last"}, bus.packet_data_last, last);
    chk({tag, "_remain"}, bus.packet_data_remain, 256'(rem));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_acc_ready"}, bus.acc_data_ready, 1'b0);
    chk({tag, "_valid"}, bus.packet_data_valid, 1'b0);
    chk({tag, "_last"}, bus.packet_data_last, 1'b0);
    chk({tag, "_remain"}, bus.packet_data_remain, 0);
    chk({tag, "_data"}, bus.packet_data, 0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_idle"}, framer_idle, 1'b1);
  endtask

  initial begin
    hresetn               = 1'b0;
    cfg_block_packets     = 7'd0;
    framer_abort          = 1'b0;
    bus.acc_data          = '0;
    bus.acc_data_valid    = 1'b0;
    bus.packet_data_ready = 1'b0;

    // Reset state
    step(); step(); step();
    chk_reset_vals("rst");
`ifdef WRAPPER_PACKET_FRAMER_STATS_EN
    chk("rst_block_count", block_count, 0);
`endif
    hresetn = 1'b1;
    step();
    chk("rst_release_ready", bus.acc_data_ready, 1'b1);

    // Block of 3, consumer always ready
    cfg_block_packets     = 7'd3;
    bus.packet_data_ready = 1'b1;
    bus.acc_data_valid    = 1'b1;
    bus.acc_data = pkt(1); step();
    chk_head("b3_p1", 1, 1'b0, 2);
    chk("b3_p1_idle", framer_idle, 1'b0);
    bus.acc_data = pkt(2); step();
    chk_head("b3_p2", 2, 1'b0, 1);
    bus.acc_data = pkt(3); step();
    chk_head("b3_p3", 3, 1'b1, 0);
    bus.acc_data_valid = 1'b0;
    step();
    chk("b3_valid_end", bus.packet_data_valid, 1'b0);
    chk("b3_level_end", fifo_level, 0);
    chk("b3_idle_end", framer_idle, 1'b1);

    // Single-packet blocks: cfg 0, 1, 1
`ifdef WRAPPER_PACKET_FRAMER_STATS_EN
    bc_base = block_count;
`endif
    bus.packet_data_ready = 1'b0;
    bus.acc_data_valid    = 1'b1;
    cfg_block_packets = 7'd0; bus.acc_data = pkt(10); step();
    cfg_block_packets = 7'd1; bus.acc_data = pkt(11); step();
    cfg_block_packets = 7'd1; bus.acc_data = pkt(12); step();
    bus.acc_data_valid = 1'b0;
    chk("single_level", fifo_level, 3);
    chk_head("single_p10", 10, 1'b1, 0);
    bus.packet_data_ready = 1'b1;
    step();
    chk_head("single_p11", 11, 1'b1, 0);
    step();
    chk_head("single_p12", 12, 1'b1, 0);
    step();
    chk("single_idle", framer_idle, 1'b1);
    chk("single_level_end", fifo_level, 0);
`ifdef WRAPPER_PACKET_FRAMER_STATS_EN
    chk("single_block_count", 16'(block_count - bc_base), 3);
`endif

    // Full FIFO: 5 offered with consumer stalled
    bus.packet_data_ready = 1'b0;
    cfg_block_packets     = 7'd8;
    bus.acc_data_valid    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.acc_data = pkt(20 + i);
      step();
    end
    chk("full_level", fifo_level, 4);
    chk("full_ready", bus.acc_data_ready, 1'b0);
    bus.acc_data = pkt(24);
    step();
    chk("full_hold_level", fifo_level, 4);
    chk_head("full_head", 20, 1'b0, 7);
    bus.packet_data_ready = 1'b1;
    step();
    bus.packet_data_ready = 1'b0;
    chk("full_pop_level", fifo_level, 3);
    chk("full_pop_ready", bus.acc_data_ready, 1'b1);
    chk_head("full_p21", 21, 1'b0, 6);
    step();
    bus.acc_data_valid = 1'b0;
    chk("full_p24_level", fifo_level, 4);
    chk("full_p24_ready", bus.acc_data_ready, 1'b0);
    bus.packet_data_ready = 1'b1;
    step(); chk_head("full_p22", 22, 1'b0, 5);
    step(); chk_head("full_p23", 23, 1'b0, 4);
    step(); chk_head("full_p24", 24, 1'b0, 3);
    step();
    chk("full_drained_valid", bus.packet_data_valid, 1'b0);
    chk("full_active_not_idle", framer_idle, 1'b0);
    framer_abort = 1'b1; step(); framer_abort = 1'b0;
    chk("clear_idle", framer_idle, 1'b1);

    // Abort with level 3, ACTIVE cnt 4, push and pop offered
    bus.packet_data_ready = 1'b0;
    bus.acc_data_valid    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.acc_data = pkt(30 + i);
      step();
    end
    chk("abort_pre_level", fifo_level, 3);
    bus.acc_data          = pkt(33);
    bus.packet_data_ready = 1'b1;
    framer_abort          = 1'b1;
    step();
    framer_abort          = 1'b0;
    bus.acc_data_valid    = 1'b0;
    bus.packet_data_ready = 1'b0;
    chk("abort_level", fifo_level, 0);
    chk("abort_valid", bus.packet_data_valid, 1'b0);
    chk("abort_idle", framer_idle, 1'b1);
    chk("abort_ready", bus.acc_data_ready, 1'b1);
    cfg_block_packets  = 7'd2;
    bus.acc_data_valid = 1'b1;
    bus.acc_data = pkt(34); step();
    bus.acc_data = pkt(35); step();
    bus.acc_data_valid = 1'b0;
    chk_head("abort_p34", 34, 1'b0, 1);
    bus.packet_data_ready = 1'b1;
    step();
    chk_head("abort_p35", 35, 1'b1, 0);
    step();
    chk("abort_drain_idle", framer_idle, 1'b1);

    // Maximum block length, cfg change mid-block ignored
    cfg_block_packets  = 7'd64;
    bus.acc_data_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.acc_data = pkt(100 + i);
      step();
      if (i == 0) cfg_block_packets = 7'd5;
      chk("max_remain", bus.packet_data_remain, 256'(63 - i));
      chk("max_last", bus.packet_data_last, (i == 63));
      if (i == 0 || i == 63) chk("max_data", bus.packet_data, pkt(100 + i));
    end
    bus.acc_data_valid = 1'b0;
    step();
    chk("max_idle", framer_idle, 1'b1);

    // Reset mid-block with level 2
    bus.packet_data_ready = 1'b0;
    cfg_block_packets     = 7'd8;
    bus.acc_data_valid    = 1'b1;
    bus.acc_data = pkt(40); step();
    bus.acc_data = pkt(41); step();
    bus.acc_data_valid = 1'b0;
    chk("mid_rst_pre_level", fifo_level, 2);
    hresetn = 1'b0;
    step();
    chk_reset_vals("mid_rst");
`ifdef WRAPPER_PACKET_FRAMER_STATS_EN
    chk("mid_rst_block_count", block_count, 0);
`endif
    hresetn = 1'b1;
    step();
    chk("mid_rst_release_ready", bus.acc_data_ready, 1'b1);
    cfg_block_packets  = 7'd3;
    bus.acc_data_valid = 1'b1;
    bus.acc_data = pkt(50);
    step();
    bus.acc_data_valid = 1'b0;
    chk_head("mid_rst_fresh", 50, 1'b0, 2);
    chk("mid_rst_fresh_level", fifo_level, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
